// File: rtl/tx_word_queue.sv
// tx_word_queue
//   Buffers 16-bit words from the core. Hands them one at a time to the
//   transceiver send port. Each word is issued with a one-cycle
//   data_send_valid pulse. data_send is held stable until data_send_done
//   arrives. A watchdog re-issues the head word if done never comes. After
//   MAX_RETRY re-issues the word is dropped, err_timeout pulses and
//   drop_count advances.
//
// Ports
//   clk             : clock, rising edge
//   rstb            : asynchronous active-high reset
//   wr_data         : word from the core
//   wr_valid        : wr_data valid; accepted when wr_valid & wr_ready
//   wr_ready        : queue not full
//   data_send       : word to the transceiver, held from issue to done/timeout
//   data_send_valid : one-cycle issue pulse
//   data_send_done  : one-cycle pulse, word fully transmitted
//   count           : words held, including the in-flight head
//   busy            : high in ISSUE or WAIT
//   err_timeout     : one-cycle pulse when a word is dropped
//   drop_count      : dropped words, saturating at 255
module tx_word_queue #(
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_CLKS = 16384,
  parameter int MAX_RETRY    = 2
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [15:0]              wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [15:0]              data_send,
  output logic                     data_send_valid,
  input  logic                     data_send_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam int RW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [15:0]    data_send_q, data_send_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [7:0]     drop_q, drop_d;

  logic [15:0]    mem_q [DEPTH];
  logic [15:0]    head;
  logic           push;
  logic           pop;

  // Full check uses the registered count only, so a pop on the same edge
  // never frees a slot for a write.
  assign wr_ready        = (count_q != CW'(DEPTH));
  assign push            = wr_valid & wr_ready;
  assign head            = mem_q[rd_ptr_q];

  assign data_send       = data_send_q;
  assign data_send_valid = valid_q;
  assign count           = count_q;
  assign busy            = (state_q != IDLE);
  assign err_timeout     = err_q;
  assign drop_count      = drop_q;

  // Storage array has no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Issue/wait sequencing. The head leaves the FIFO only on done or drop.
  // Done takes priority over timer expiry.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    data_send_d = data_send_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    drop_d      = drop_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d     = ISSUE;
          data_send_d = head;
          valid_d     = 1'b1;
          timer_d     = '0;
          retry_d     = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (data_send_done) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT_CLKS - 1)) begin
          if (retry_q != RW'(MAX_RETRY)) begin
            retry_d     = retry_q + RW'(1);
            state_d     = ISSUE;
            data_send_d = head;
            valid_d     = 1'b1;
            timer_d     = '0;
          end else begin
            pop     = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
            if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a simultaneous push and pop leaves
  // the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Register stage for all control state and outputs.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      data_send_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      data_send_q <= data_send_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_tx_word_queue.sv
// tb_tx_word_queue
//   Directed bench for tx_word_queue with DEPTH=8, TIMEOUT_CLKS=16,
//   MAX_RETRY=2. Inputs change 1ns after a rising edge. Outputs are
//   sampled at that same point.
module tb_tx_word_queue;

  logic        clk;
  logic        rstb;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] data_send;
  logic        data_send_valid;
  logic        data_send_done;
  logic [3:0]  count;
  logic        busy;
  logic        err_timeout;
  logic [7:0]  drop_count;

  int checks   = 0;
  int failures = 0;

  tx_word_queue #(
    .DEPTH        (8),
    .TIMEOUT_CLKS (16),
    .MAX_RETRY    (2)
  ) dut (
    .clk             (clk),
    .rstb            (rstb),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .data_send       (data_send),
    .data_send_valid (data_send_valid),
    .data_send_done  (data_send_done),
    .count           (count),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One write cycle: present the word for a single edge.
  task automatic applyStimulus(input logic [15:0] word);
    wr_valid = 1'b1;
    wr_data  = word;
    stepClk();
    wr_valid = 1'b0;
  endtask

  // From IDLE with words queued: expect the issue, then complete it with done.
  task automatic serveHead(input logic [15:0] expWord, input int expCount);
    stepClk();
    checkOutput("serve_valid", 32'(data_send_valid), 32'd1);
    checkOutput("serve_data", 32'(data_send), 32'(expWord));
    stepClk();
    data_send_done = 1'b1;
    stepClk();
    data_send_done = 1'b0;
    checkOutput("serve_count", 32'(count), 32'(expCount));
  endtask

  initial begin
    logic sawValid;
    rstb           = 1'b1;
    wr_data        = '0;
    wr_valid       = 1'b0;
    data_send_done = 1'b0;

    // Reset state
    stepClk();
    stepClk();
    rstb = 1'b0;
    stepClk();
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(data_send_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    checkOutput("rst_drop", 32'(drop_count), 32'd0);
    checkOutput("rst_data", 32'(data_send), 32'd0);

    // 1: single word, valid two edges after the write, done 10 cycles in
    applyStimulus(16'hA5A5);
    checkOutput("t1_count", 32'(count), 32'd1);
    checkOutput("t1_novalid_early", 32'(data_send_valid), 32'd0);
    stepClk();
    checkOutput("t1_valid", 32'(data_send_valid), 32'd1);
    checkOutput("t1_data", 32'(data_send), 32'hA5A5);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    stepClk();
    checkOutput("t1_valid_drop", 32'(data_send_valid), 32'd0);
    checkOutput("t1_hold", 32'(data_send), 32'hA5A5);
    repeat (9) stepClk();
    data_send_done = 1'b1;
    stepClk();
    data_send_done = 1'b0;
    checkOutput("t1_count_done", 32'(count), 32'd0);
    checkOutput("t1_busy_done", 32'(busy), 32'd0);
    checkOutput("t1_hold_idle", 32'(data_send), 32'hA5A5);

    // 2: fill with 1..8, ninth write refused, drain in order
    for (int i = 1; i <= 8; i++) applyStimulus(16'(i));
    checkOutput("t2_count_full", 32'(count), 32'd8);
    checkOutput("t2_wr_ready", 32'(wr_ready), 32'd0);
    applyStimulus(16'h0009);
    checkOutput("t2_count_refused", 32'(count), 32'd8);
    checkOutput("t2_head", 32'(data_send), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      data_send_done = 1'b1;
      stepClk();
      data_send_done = 1'b0;
      checkOutput("t2_count_pop", 32'(count), 32'(8 - k));
      checkOutput("t2_gap_busy", 32'(busy), 32'd0);
      if (k < 8) begin
        stepClk();
        checkOutput("t2_valid", 32'(data_send_valid), 32'd1);
        checkOutput("t2_order", 32'(data_send), 32'(k + 1));
        stepClk();
      end
    end

    // 3: no done; three issues 17 cycles apart, then drop and move on
    applyStimulus(16'h0BAD);
    applyStimulus(16'h0C0D);
    checkOutput("t3_valid0", 32'(data_send_valid), 32'd1);
    checkOutput("t3_data0", 32'(data_send), 32'h0BAD);
    for (int r = 1; r <= 2; r++) begin
      sawValid = 1'b0;
      for (int i = 0; i < 16; i++) begin
        stepClk();
        if (data_send_valid) sawValid = 1'b1;
      end
      checkOutput("t3_quiet", 32'(sawValid), 32'd0);
      stepClk();
      checkOutput("t3_reissue", 32'(data_send_valid), 32'd1);
      checkOutput("t3_same_word", 32'(data_send), 32'h0BAD);
      checkOutput("t3_err_low", 32'(err_timeout), 32'd0);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      stepClk();
      if (data_send_valid || err_timeout) sawValid = 1'b1;
    end
    checkOutput("t3_quiet_last", 32'(sawValid), 32'd0);
    stepClk();
    checkOutput("t3_err", 32'(err_timeout), 32'd1);
    checkOutput("t3_drop_count", 32'(drop_count), 32'd1);
    checkOutput("t3_count", 32'(count), 32'd1);
    checkOutput("t3_no_fourth", 32'(data_send_valid), 32'd0);
    stepClk();
    checkOutput("t3_err_pulse", 32'(err_timeout), 32'd0);
    checkOutput("t3_next_valid", 32'(data_send_valid), 32'd1);
    checkOutput("t3_next_data", 32'(data_send), 32'h0C0D);
    stepClk();
    data_send_done = 1'b1;
    stepClk();
    data_send_done = 1'b0;
    checkOutput("t3_empty", 32'(count), 32'd0);

    // 4: done on the expiry cycle wins over retry
    applyStimulus(16'h4444);
    stepClk();
    checkOutput("t4_valid", 32'(data_send_valid), 32'd1);
    repeat (16) stepClk();
    data_send_done = 1'b1;
    stepClk();
    data_send_done = 1'b0;
    checkOutput("t4_count", 32'(count), 32'd0);
    checkOutput("t4_err", 32'(err_timeout), 32'd0);
    checkOutput("t4_no_reissue", 32'(data_send_valid), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_drop_count", 32'(drop_count), 32'd1);
    stepClk();
    checkOutput("t4_still_idle", 32'(busy), 32'd0);

    // 5: write refused when full even with a pop; push+pop keeps count
    for (int i = 1; i <= 8; i++) applyStimulus(16'(16'h0050 + i));
    checkOutput("t5_full", 32'(count), 32'd8);
    wr_valid       = 1'b1;
    wr_data        = 16'h00EE;
    data_send_done = 1'b1;
    stepClk();
    wr_valid       = 1'b0;
    data_send_done = 1'b0;
    checkOutput("t5_count_full_pop", 32'(count), 32'd7);
    checkOutput("t5_wr_ready", 32'(wr_ready), 32'd1);
    serveHead(16'h0052, 6);
    serveHead(16'h0053, 5);
    serveHead(16'h0054, 4);
    stepClk();
    checkOutput("t5_issue55", 32'(data_send), 32'h0055);
    stepClk();
    wr_valid       = 1'b1;
    wr_data        = 16'h0099;
    data_send_done = 1'b1;
    stepClk();
    wr_valid       = 1'b0;
    data_send_done = 1'b0;
    checkOutput("t5_count_pushpop", 32'(count), 32'd4);
    serveHead(16'h0056, 3);
    serveHead(16'h0057, 2);
    serveHead(16'h0058, 1);
    serveHead(16'h0099, 0);

    // 6: reset while waiting with 3 words queued; stray done afterwards
    applyStimulus(16'h6001);
    applyStimulus(16'h6002);
    applyStimulus(16'h6003);
    checkOutput("t6_pre_count", 32'(count), 32'd3);
    checkOutput("t6_pre_busy", 32'(busy), 32'd1);
    rstb = 1'b1;
    #1;
    checkOutput("t6_count", 32'(count), 32'd0);
    checkOutput("t6_valid", 32'(data_send_valid), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_wr_ready", 32'(wr_ready), 32'd1);
    stepClk();
    rstb = 1'b0;
    data_send_done = 1'b1;
    stepClk();
    data_send_done = 1'b0;
    checkOutput("t6_stray_count", 32'(count), 32'd0);
    checkOutput("t6_stray_busy", 32'(busy), 32'd0);
    checkOutput("t6_stray_drop", 32'(drop_count), 32'd0);
    checkOutput("t6_stray_err", 32'(err_timeout), 32'd0);
    applyStimulus(16'h7777);
    serveHead(16'h7777, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
